// File: rtl/aes_round_sequencer_pkg.sv
// Shared definitions for the AES round sequencer: round count, key-index width
// and the sequencer state type.
package AESDefinitions;

    localparam int NUM_ROUNDS = 10;
    localparam int KEY_IDX_W  = $clog2(NUM_ROUNDS + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ROUND = 3'd2,
        FINAL = 3'd3,
        HOLD  = 3'd4
    } seq_state_e;

endpackage

// File: rtl/aes_round_sequencer_round_counter.sv
// Up counter for the cipher round number with synchronous clear (priority over
// enable) and a flag that is high while the count equals TERM.
module round_counter #(
    parameter int W    = 4,
    parameter int TERM = 9
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic         at_term_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign at_term_o = (count_q == W'(TERM));

endmodule

// File: rtl/aes_round_sequencer.sv
// AES round sequencer: Moore FSM stepping the datapath through load, rounds and
// result hold. Define AES_DECRYPT_EN to support reverse (decrypt) key order.
//
// state | meaning
// IDLE  | ready for a block, counter cleared
// LOAD  | load block, initial AddRoundKey
// ROUND | full round r = 1 .. NUM_ROUNDS-1
// FINAL | last round (no MixColumns)
// HOLD  | result valid until consumer accepts
module aes_round_sequencer #(
    parameter int NUM_ROUNDS = AESDefinitions::NUM_ROUNDS,
    parameter int IDX_W      = $clog2(NUM_ROUNDS + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inValid,
    output logic             inReady,
    input  logic             decrypt,
    output logic             loadState,
    output logic             roundEn,
    output logic             lastRound,
    output logic [IDX_W-1:0] keyIdx,
    output logic             outValid,
    input  logic             outReady,
    output logic             busy
);

    import AESDefinitions::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS);

    seq_state_e       state_q;
    seq_state_e       state_d;
    logic             cnt_clr;
    logic             cnt_en;
    logic [IDX_W-1:0] round_cnt;
    logic             cnt_at_term;
    logic             dec_mode;

    round_counter #(
        .W    (IDX_W),
        .TERM (NUM_ROUNDS - 1)
    ) u_round_counter (
        .clock     (clock),
        .reset     (reset),
        .clr_i     (cnt_clr),
        .en_i      (cnt_en),
        .count_o   (round_cnt),
        .at_term_o (cnt_at_term)
    );

`ifdef AES_DECRYPT_EN
    logic dec_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dec_q <= 1'b0;
        end else if (state_q == IDLE && inValid) begin
            dec_q <= decrypt;
        end
    end

    assign dec_mode = dec_q;
`else
    logic decrypt_unused;

    assign decrypt_unused = decrypt;
    assign dec_mode       = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (inValid) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_en  = 1'b1;
                state_d = ROUND;
            end
            ROUND: begin
                // Counter reaches NUM_ROUNDS in FINAL and stops there.
                cnt_en = 1'b1;
                if (cnt_at_term) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (outReady) begin
                    state_d = IDLE;
                    cnt_clr = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        inReady   = 1'b0;
        busy      = 1'b1;
        loadState = 1'b0;
        roundEn   = 1'b0;
        lastRound = 1'b0;
        outValid  = 1'b0;
        keyIdx    = '0;
        unique case (state_q)
            IDLE: begin
                inReady = 1'b1;
                busy    = 1'b0;
            end
            LOAD: begin
                loadState = 1'b1;
                keyIdx    = dec_mode ? LAST_IDX : '0;
            end
            ROUND: begin
                roundEn = 1'b1;
                keyIdx  = dec_mode ? (LAST_IDX - round_cnt) : round_cnt;
            end
            FINAL: begin
                roundEn   = 1'b1;
                lastRound = 1'b1;
                keyIdx    = dec_mode ? '0 : LAST_IDX;
            end
            HOLD: begin
                outValid = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer: directed scenarios followed by
// random handshakes, checked each cycle against a cycle-offset reference model.
module tb_aes_round_sequencer;

    localparam int NR = 10;
    localparam int W  = $clog2(NR + 1);

    logic         clock = 1'b0;
    logic         reset;
    logic         inValid;
    logic         inReady;
    logic         decrypt;
    logic         loadState;
    logic         roundEn;
    logic         lastRound;
    logic [W-1:0] keyIdx;
    logic         outValid;
    logic         outReady;
    logic         busy;

    int total = 0;
    int bad   = 0;

    // Model: m_k counts cycles since the accept edge (1 = load cycle).
    bit m_act = 1'b0;
    int m_k   = 0;
    bit m_dec = 1'b0;

    aes_round_sequencer #(.NUM_ROUNDS(NR)) dut (
        .clock     (clock),
        .reset     (reset),
        .inValid   (inValid),
        .inReady   (inReady),
        .decrypt   (decrypt),
        .loadState (loadState),
        .roundEn   (roundEn),
        .lastRound (lastRound),
        .keyIdx    (keyIdx),
        .outValid  (outValid),
        .outReady  (outReady),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    function automatic logic [W+5:0] expected_vec();
        logic         ir, bz, ld, re, lr, ov;
        logic [W-1:0] ki;
        int           p;
        ir = !m_act;
        bz = m_act;
        ld = m_act && (m_k == 1);
        re = m_act && (m_k >= 2) && (m_k <= NR + 1);
        lr = m_act && (m_k == NR + 1);
        ov = m_act && (m_k >= NR + 2);
        ki = '0;
        if (m_act && m_k >= 1 && m_k <= NR + 1) begin
            p  = m_k - 1;
            ki = m_dec ? W'(NR - p) : W'(p);
        end
        return {ir, bz, ld, re, lr, ov, ki};
    endfunction

    task automatic check(input string tag);
        logic [W+5:0] obs;
        logic [W+5:0] exp_v;
        obs   = {inReady, busy, loadState, roundEn, lastRound, outValid, keyIdx};
        exp_v = expected_vec();
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h (k=%0d)", tag, obs, exp_v, m_k);
        end
        total++;
        assert ($countones({loadState, roundEn, outValid}) <= 1) else begin
            bad++;
            $error("FAIL %s_excl observed=%b expected=at most one set", tag,
                   {loadState, roundEn, outValid});
        end
    endtask

    task automatic step(input bit iv, input bit dec, input bit ordy, input string tag);
        inValid  = iv;
        decrypt  = dec;
        outReady = ordy;
        @(posedge clock);
        if (!reset) begin
            m_act = 1'b0;
            m_k   = 0;
        end else if (!m_act) begin
            if (inValid) begin
                m_act = 1'b1;
                m_k   = 1;
`ifdef AES_DECRYPT_EN
                m_dec = decrypt;
`else
                m_dec = 1'b0;
`endif
            end
        end else if (m_k >= NR + 2) begin
            if (outReady) begin
                m_act = 1'b0;
                m_k   = 0;
            end
        end else begin
            m_k++;
        end
        #1;
        check(tag);
    endtask

    task automatic async_reset(input string tag);
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        m_act = 1'b0;
        m_k   = 0;
        check(tag);
        step(1, 0, 0, {tag, "_held"});
        step(1, 0, 1, {tag, "_held"});
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        reset    = 1'b0;
        inValid  = 1'b0;
        decrypt  = 1'b0;
        outReady = 1'b0;
        #12;
        check("rst_active");
        @(negedge clock);
        reset = 1'b1;
        step(0, 0, 0, "post_rst");

        // Encrypt, consumer stalls then accepts.
        step(1, 0, 0, "enc_accept");
        repeat (17) step(0, 0, 0, "enc_stall");
        step(0, 0, 1, "enc_handshake");
        step(0, 0, 0, "enc_idle");

        // inValid pulsed while busy must not queue a second block.
        step(1, 0, 0, "busy_accept");
        repeat (3) step(0, 0, 0, "busy_run");
        step(1, 1, 0, "busy_pulse");
        repeat (20) step(0, 0, 1, "busy_drain");

        // Reverse key order when enabled.
        step(1, 1, 0, "dec_accept");
        repeat (14) step(0, 1, 1, "dec_run");

        // Reset mid-operation discards the block.
        step(1, 0, 0, "rst_accept");
        repeat (5) step(0, 0, 0, "rst_run");
        async_reset("rst_mid");
        step(0, 0, 1, "rst_released");
        step(1, 0, 0, "rst_reaccept");
        repeat (15) step(0, 0, 1, "rst_rerun");

        // Back-to-back with outReady already high on HOLD entry.
        repeat (45) step(1, 0, 1, "b2b");

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                async_reset("rnd_rst");
            end
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
